// File: rtl/alu_nibble_sequencer_pkg.sv
// Shared types for the nibble sequencer and its 4-bit ALU slice.
// FSM state encoding plus the S select codes both sides agree on.
package alu_nibble_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // arithmetic (M=0) selects, carry_in adds one
  localparam logic [3:0] S_A         = 4'b0000;
  localparam logic [3:0] S_SUB       = 4'b0110;
  localparam logic [3:0] S_ADD       = 4'b1001;
  localparam logic [3:0] S_A_MINUS_1 = 4'b1111;

  // logic (M=1) selects
  localparam logic [3:0] S_ZERO      = 4'b0011;
  localparam logic [3:0] S_XOR       = 4'b0110;
  localparam logic [3:0] S_AND       = 4'b1011;
  localparam logic [3:0] S_ONES      = 4'b1100;

endpackage

// File: rtl/alu_nibble_sequencer_if.sv
// Request/result handshake bundle of the nibble sequencer.
// Signal suffixes are from the sequencer's point of view.
interface alu_nibble_sequencer_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start_valid_i;
  logic         start_ready_o;
  logic [W-1:0] op_a_i;
  logic [W-1:0] op_b_i;
  logic [3:0]   sel_i;
  logic         mode_i;
  logic         carry_in_i;

  logic         res_valid_o;
  logic         res_ready_i;
  logic [W-1:0] res_o;
  logic         res_carry_o;
  logic         res_zero_o;

  modport master (
    output start_valid_i, op_a_i, op_b_i,
    output sel_i, mode_i, carry_in_i,
    output res_ready_i,
    input  start_ready_o, res_valid_o,
    input  res_o, res_carry_o, res_zero_o
  );

  modport slave (
    input  start_valid_i, op_a_i, op_b_i,
    input  sel_i, mode_i, carry_in_i,
    input  res_ready_i,
    output start_ready_o, res_valid_o,
    output res_o, res_carry_o, res_zero_o
  );

endinterface

// File: rtl/alu_nibble_sequencer_collector.sv
// Result register: one nibble written per RUN cycle, LSB first.
// The zero flag is derived from the stored result.
module nibble_result_collector #(
  parameter int NIBBLES = 4,
  parameter int KW      = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              we_i,
  input  logic [KW-1:0]     idx_i,
  input  logic [3:0]        nib_i,
  output logic [4*NIBBLES-1:0] res_o,
  output logic              zero_o
);
  localparam int W = 4 * NIBBLES;

  logic [W-1:0] res_q, res_d;

  always_comb begin
    res_d = res_q;
    if (we_i) begin
      res_d[{idx_i, 2'b00} +: 4] = nib_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  assign res_o  = res_q;
  assign zero_o = (res_q == '0);

endmodule

// File: rtl/alu_nibble_sequencer.sv
// Nibble-serial sequencer driving a 4-bit 74181-style ALU slice.
// Owns the FSM, the inter-nibble carry and the slice drive.
module alu_nibble_sequencer
  import alu_nibble_sequencer_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  alu_nibble_sequencer_if.slave io,
  output logic [3:0] alu_s_o,
  output logic       alu_m_o,
  output logic       alu_cn_o,
  output logic [3:0] alu_a_o,
  output logic [3:0] alu_b_o,
  input  logic [3:0] alu_f_i,
  input  logic       alu_cout_i
);
  localparam int W  = 4 * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [3:0]    s_q, s_d;
  logic          m_q, m_d;
  logic          cin_q, cin_d;
  logic          carry_q, carry_d;
  logic [KW-1:0] k_q, k_d;
  logic          vld_q, vld_d;
  logic          wr_en;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    s_d      = s_q;
    m_d      = m_q;
    cin_d    = cin_q;
    carry_d  = carry_q;
    k_d      = k_q;
    vld_d    = vld_q;
    wr_en    = 1'b0;
    alu_a_o  = '0;
    alu_b_o  = '0;
    alu_s_o  = '0;
    alu_m_o  = 1'b0;
    alu_cn_o = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (io.start_valid_i) begin
          a_d     = io.op_a_i;
          b_d     = io.op_b_i;
          s_d     = io.sel_i;
          m_d     = io.mode_i;
          cin_d   = io.carry_in_i;
          carry_d = 1'b0;
          k_d     = '0;
          state_d = RUN;
        end
      end
      (state_q == RUN): begin
        alu_a_o  = a_q[{k_q, 2'b00} +: 4];
        alu_b_o  = b_q[{k_q, 2'b00} +: 4];
        alu_s_o  = s_q;
        alu_m_o  = m_q;
        // logic mode has no ripple, so every nibble sees the initial carry
        alu_cn_o = (k_q == '0 || m_q) ? cin_q : carry_q;
        wr_en    = 1'b1;
        carry_d  = alu_cout_i;
        if (k_q == K_LAST) begin
          state_d = DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      (state_q == DONE): begin
        // valid is registered, so it rises one edge after DONE is entered
        vld_d = 1'b1;
        if (vld_q && io.res_ready_i) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      k_q     <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      m_q     <= m_d;
      cin_q   <= cin_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      vld_q   <= vld_d;
    end
  end

  nibble_result_collector #(
    .NIBBLES (NIBBLES),
    .KW      (KW)
  ) u_collect (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .we_i    (wr_en),
    .idx_i   (k_q),
    .nib_i   (alu_f_i),
    .res_o   (io.res_o),
    .zero_o  (io.res_zero_o)
  );

  assign io.start_ready_o = (state_q == IDLE);
  assign io.res_valid_o   = vld_q;
  assign io.res_carry_o   = m_q ? 1'b0 : carry_q;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Directed bench for the nibble sequencer with a 74181 slice model.
// Vector table for the main function plus backpressure/reset sequences.
module tb_alu_nibble_sequencer;
  import alu_nibble_sequencer_pkg::*;

  typedef struct {
    logic        m;
    logic [3:0]  s;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_res;
    logic        exp_c;
    logic        exp_z;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] alu_s, alu_a, alu_b, alu_f;
  logic       alu_m, alu_cn, alu_cout;
  logic [3:0] p_t, g_t;
  logic [4:0] sum_t;

  int tests = 0;
  int fails = 0;

  vec_t vecs [10];

  alu_nibble_sequencer_if #(.NIBBLES(4)) bus ();

  alu_nibble_sequencer #(.NIBBLES(4)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .io         (bus.slave),
    .alu_s_o    (alu_s),
    .alu_m_o    (alu_m),
    .alu_cn_o   (alu_cn),
    .alu_a_o    (alu_a),
    .alu_b_o    (alu_b),
    .alu_f_i    (alu_f),
    .alu_cout_i (alu_cout)
  );

  // 74181 slice, active-high data, active-high carry
  assign p_t = alu_a | (alu_b & {4{alu_s[0]}}) | (~alu_b & {4{alu_s[1]}});
  assign g_t = (alu_a & ~alu_b & {4{alu_s[2]}}) | (alu_a & alu_b & {4{alu_s[3]}});
  assign sum_t = {1'b0, p_t} + {1'b0, g_t} + {4'b0, alu_cn};
  assign alu_f = alu_m ? (p_t ^ ~g_t) : sum_t[3:0];
  assign alu_cout = sum_t[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input bit release_res, input string tag);
    logic prev_c;
    logic exp_cn;
    chk({tag, " start_ready"}, 32'(bus.start_ready_o), 32'd1);
    bus.op_a_i        = v.a;
    bus.op_b_i        = v.b;
    bus.sel_i         = v.s;
    bus.mode_i        = v.m;
    bus.carry_in_i    = v.cin;
    bus.start_valid_i = 1'b1;
    tick();
    bus.start_valid_i = 1'b0;
    prev_c = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_cn = (k == 0 || v.m) ? v.cin : prev_c;
      chk({tag, " nib_a"}, 32'(alu_a), 32'(v.a[4*k +: 4]));
      chk({tag, " nib_b"}, 32'(alu_b), 32'(v.b[4*k +: 4]));
      chk({tag, " sel"}, 32'(alu_s), 32'(v.s));
      chk({tag, " mode"}, 32'(alu_m), 32'(v.m));
      chk({tag, " cn"}, 32'(alu_cn), 32'(exp_cn));
      chk({tag, " busy"}, 32'(bus.start_ready_o), 32'd0);
      chk({tag, " early_valid"}, 32'(bus.res_valid_o), 32'd0);
      prev_c = alu_cout;
      tick();
    end
    chk({tag, " valid_at_4"}, 32'(bus.res_valid_o), 32'd0);
    chk({tag, " done_drive"}, 32'({alu_a, alu_b, alu_s, alu_m, alu_cn}), 32'd0);
    tick();
    chk({tag, " valid_at_5"}, 32'(bus.res_valid_o), 32'd1);
    chk({tag, " res"}, 32'(bus.res_o), 32'(v.exp_res));
    chk({tag, " carry"}, 32'(bus.res_carry_o), 32'(v.exp_c));
    chk({tag, " zero"}, 32'(bus.res_zero_o), 32'(v.exp_z));
    if (release_res) begin
      bus.res_ready_i = 1'b1;
      tick();
      bus.res_ready_i = 1'b0;
      chk({tag, " valid_drop"}, 32'(bus.res_valid_o), 32'd0);
      chk({tag, " idle"}, 32'(bus.start_ready_o), 32'd1);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " valid"}, 32'(bus.res_valid_o), 32'd0);
    chk({tag, " res"}, 32'(bus.res_o), 32'd0);
    chk({tag, " carry"}, 32'(bus.res_carry_o), 32'd0);
    chk({tag, " zero"}, 32'(bus.res_zero_o), 32'd1);
    chk({tag, " ready"}, 32'(bus.start_ready_o), 32'd1);
    chk({tag, " alu"}, 32'({alu_a, alu_b, alu_s, alu_m, alu_cn}), 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, S_ADD,       1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{1'b0, S_ADD,       1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1};
    vecs[2] = '{1'b0, S_SUB,       1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
    vecs[3] = '{1'b1, S_XOR,       1'b0, 16'hA5A5, 16'hFFFF, 16'h5A5A, 1'b0, 1'b0};
    vecs[4] = '{1'b0, S_SUB,       1'b1, 16'h0007, 16'h0005, 16'h0002, 1'b1, 1'b0};
    vecs[5] = '{1'b0, S_A,         1'b1, 16'h00FF, 16'h1234, 16'h0100, 1'b0, 1'b0};
    vecs[6] = '{1'b1, S_AND,       1'b1, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0};
    vecs[7] = '{1'b1, S_ZERO,      1'b0, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1};
    vecs[8] = '{1'b1, S_ONES,      1'b1, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 1'b0};
    vecs[9] = '{1'b0, S_A_MINUS_1, 1'b0, 16'h0000, 16'hABCD, 16'hFFFF, 1'b0, 1'b0};

    rst_n             = 1'b0;
    bus.start_valid_i = 1'b0;
    bus.op_a_i        = '0;
    bus.op_b_i        = '0;
    bus.sel_i         = '0;
    bus.mode_i        = 1'b0;
    bus.carry_in_i    = 1'b0;
    bus.res_ready_i   = 1'b0;
    #2;
    chk_reset_outputs("por");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk_reset_outputs("post_por");

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], 1'b1, $sformatf("vec%0d", i));
    end

    // backpressure: result held, new requests ignored
    run_vec(vecs[0], 1'b0, "bp");
    bus.op_a_i = 16'hFFFF;
    bus.op_b_i = 16'hFFFF;
    bus.sel_i  = S_XOR;
    bus.mode_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      bus.start_valid_i = (c >= 3 && c <= 5);
      tick();
      chk("bp res_stable", 32'(bus.res_o), 32'h2233);
      chk("bp valid_held", 32'(bus.res_valid_o), 32'd1);
      chk("bp not_ready", 32'(bus.start_ready_o), 32'd0);
      chk("bp carry_stable", 32'(bus.res_carry_o), 32'd0);
      chk("bp no_drive", 32'(alu_a), 32'd0);
    end
    bus.start_valid_i = 1'b0;
    bus.res_ready_i   = 1'b1;
    tick();
    bus.res_ready_i = 1'b0;
    chk("bp release_idle", 32'(bus.start_ready_o), 32'd1);
    chk("bp release_valid", 32'(bus.res_valid_o), 32'd0);
    chk("bp no_capture", 32'(bus.res_o), 32'h2233);
    tick();
    chk("bp stays_idle", 32'(bus.start_ready_o), 32'd1);
    run_vec(vecs[1], 1'b1, "bp_next");

    // reset while nibble 2 is on the slice
    bus.op_a_i        = 16'h1234;
    bus.op_b_i        = 16'h0FFF;
    bus.sel_i         = S_ADD;
    bus.mode_i        = 1'b0;
    bus.carry_in_i    = 1'b0;
    bus.start_valid_i = 1'b1;
    tick();
    bus.start_valid_i = 1'b0;
    tick();
    tick();
    chk("mid nib2_a", 32'(alu_a), 32'h2);
    chk("mid partial", 32'(bus.res_o), 32'h0033);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("mid_rst hold_valid", 32'(bus.res_valid_o), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    chk_reset_outputs("mid_rst_rel");
    run_vec(vecs[0], 1'b1, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
